// File: rtl/bram_fifo_ctrl.sv
// FIFO controller wrapped around an external simple dual-port RAM with a
// one-cycle registered read, exposing valid/ready streams on both sides.
module bram_fifo_ctrl #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          mem_wen,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] DEPTH_L = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_level;
    logic [AW:0]   count_q;
    logic [DW-1:0] obuf0;
    logic [DW-1:0] obuf1;
    logic [1:0]    obuf_cnt;
    logic          rd_pending;

    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    out_occ;
    logic [1:0]    cnt_after_pop;
    logic [1:0]    obuf_cnt_nxt;
    logic [DW-1:0] obuf0_nxt;
    logic [DW-1:0] obuf1_nxt;

    // All externally visible handshakes are forced idle while reset is held.
    assign s_ready = rst_n && (count_q < DEPTH_L);
    assign push    = s_valid && s_ready;
    assign m_valid = rst_n && (obuf_cnt != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = rst_n ? obuf0 : '0;

    // Prefetch only while the output buffer plus the read in flight stays below two.
    assign out_occ = {1'b0, obuf_cnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign issue   = rst_n && (ram_level != '0) && (out_occ < 3'd2);

    assign mem_wen   = push;
    assign mem_waddr = wptr;
    assign mem_wdata = s_data;
    assign mem_ren   = issue;
    assign mem_raddr = rptr;

    assign count = rst_n ? count_q : '0;
    assign full  = rst_n && (count_q == DEPTH_L);
    assign empty = !rst_n || (count_q == '0);

    // obuf0 is always the oldest entry; a pop shifts, a read return fills the first free slot.
    always_comb begin
        obuf0_nxt     = obuf0;
        obuf1_nxt     = obuf1;
        cnt_after_pop = obuf_cnt;
        if (pop) begin
            obuf0_nxt     = obuf1;
            cnt_after_pop = obuf_cnt - 2'd1;
        end
        obuf_cnt_nxt = cnt_after_pop;
        if (rd_pending) begin
            if (cnt_after_pop == 2'd0) begin
                obuf0_nxt = mem_rdata;
            end else begin
                obuf1_nxt = mem_rdata;
            end
            obuf_cnt_nxt = cnt_after_pop + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_level  <= '0;
            count_q    <= '0;
            obuf0      <= '0;
            obuf1      <= '0;
            obuf_cnt   <= 2'd0;
            rd_pending <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue) begin
                rptr <= rptr + 1'b1;
            end
            ram_level  <= ram_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, issue};
            count_q    <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            obuf0      <= obuf0_nxt;
            obuf1      <= obuf1_nxt;
            obuf_cnt   <= obuf_cnt_nxt;
            rd_pending <= issue;
        end
    end

    // Every accepted word lives in exactly one place: RAM, the read in flight, or obuf.
    a_level_sum : assert property (@(posedge clk) disable iff (!rst_n)
        (ram_level + {{(AW-1){1'b0}}, obuf_cnt} + {{AW{1'b0}}, rd_pending}) == count_q);

    a_obuf_bound : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, obuf_cnt} + {2'b00, rd_pending}) <= 3'd2);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl: behavioural RAM plus a queue-based
// reference model of the FIFO contents, driven with directed and random traffic.
module tb_bram_fifo_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          mem_wen;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ren;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_q[$];
    int unsigned   wr_total = 0;
    int unsigned   rd_total = 0;
    logic [DW-1:0] ram [0:DEPTH-1];

    always #5 clk = ~clk;

    bram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .count(count), .full(full), .empty(empty)
    );

    // Simple dual-port RAM with registered read; contents survive controller reset.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    // Called at the negedge: advance the reference model by the handshakes of this cycle.
    task automatic step();
        bit exp_push;
        bit do_pop;
        exp_push = rst_n && s_valid && (model_q.size() < DEPTH);
        do_pop   = rst_n && m_valid && m_ready && (model_q.size() > 0);
        if (!rst_n) begin
            model_q.delete();
            wr_total = 0;
            rd_total = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (exp_push) begin
                model_q.push_back(s_data);
                wr_total++;
            end
            if (mem_ren) rd_total++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = $urandom;
            @(negedge clk);
            tests++;
            if ({s_ready, mem_wen, mem_ren, m_valid, empty, full} !== 6'b000010) begin
                fails++;
                $display("[TB] FAIL reset_flags: got %b expected 000010", {s_ready, mem_wen, mem_ren, m_valid, empty, full});
            end
            tests++;
            if (m_data !== '0 || count !== '0) begin
                fails++;
                $display("[TB] FAIL reset_data_count: got m_data=%h count=%0d expected 0/0", m_data, count);
            end
            step();
        end
        rst_n = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready, m_valid, empty, full} !== 4'b1010 || count !== '0) begin
            fails++;
            $display("[TB] FAIL reset_release: got flags=%b count=%0d expected 1010/0", {s_ready, m_valid, empty, full}, count);
        end
        step();
    endtask

    task automatic test_single_latency();
        s_valid = 1'b1; s_data = 32'hA5A5_0001; m_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_wen !== 1'b1 || mem_waddr !== AW'(0) || mem_wdata !== 32'hA5A5_0001) begin
            fails++;
            $display("[TB] FAIL single_write: got wen=%b addr=%0d data=%h expected 1/0/a5a50001", mem_wen, mem_waddr, mem_wdata);
        end
        step();
        s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_ren !== 1'b1 || mem_raddr !== AW'(0) || count !== (AW+1)'(1) || m_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_read_issue: got ren=%b raddr=%0d count=%0d m_valid=%b expected 1/0/1/0", mem_ren, mem_raddr, count, m_valid);
        end
        step();
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b0 || mem_ren !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_cycle2: got m_valid=%b ren=%b expected 0/0", m_valid, mem_ren);
        end
        step();
        @(negedge clk);
        tests++;
        if (m_valid !== 1'b1 || m_data !== 32'hA5A5_0001) begin
            fails++;
            $display("[TB] FAIL single_output: got m_valid=%b m_data=%h expected 1/a5a50001", m_valid, m_data);
        end
        step();
        @(negedge clk);
        tests++;
        if (count !== '0 || empty !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_after_pop: got count=%0d empty=%b m_valid=%b expected 0/1/0", count, empty, m_valid);
        end
        step();
    endtask

    task automatic test_fill_full();
        int unsigned rd_start;
        int guard;
        rd_start = rd_total;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1; s_data = DW'(i);
            @(negedge clk);
            tests++;
            if (s_ready !== 1'b1 || mem_wen !== 1'b1 || mem_waddr !== AW'(wr_total % DEPTH)) begin
                fails++;
                $display("[TB] FAIL fill_write[%0d]: got ready=%b wen=%b addr=%0d expected 1/1/%0d", i, s_ready, mem_wen, mem_waddr, wr_total % DEPTH);
            end
            step();
        end
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (count !== (AW+1)'(DEPTH) || full !== 1'b1 || s_ready !== 1'b0 || mem_wen !== 1'b0) begin
            fails++;
            $display("[TB] FAIL fill_full: got count=%0d full=%b ready=%b wen=%b expected 1024/1/0/0", count, full, s_ready, mem_wen);
        end
        step();
        tests++;
        if (rd_total - rd_start != 2) begin
            fails++;
            $display("[TB] FAIL fill_reads: got %0d reads expected 2", rd_total - rd_start);
        end
        // Full with a simultaneous pop: the push must be refused.
        s_valid = 1'b1; m_ready = 1'b1; s_data = 32'hBAD0_0001;
        @(negedge clk);
        tests++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== model_q[0]) begin
            fails++;
            $display("[TB] FAIL full_pop: got ready=%b m_valid=%b m_data=%h expected 0/1/%h", s_ready, m_valid, m_data, model_q[0]);
        end
        step();
        s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (count !== (AW+1)'(DEPTH - 1) || s_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL full_pop_after: got count=%0d ready=%b expected 1023/1", count, s_ready);
        end
        guard = 0;
        while (model_q.size() > 0 && guard < 1200) begin
            tests++;
            if (m_valid !== 1'b1 || m_data !== model_q[0]) begin
                fails++;
                $display("[TB] FAIL drain_word: got m_valid=%b m_data=%h expected 1/%h", m_valid, m_data, model_q[0]);
            end
            step();
            @(negedge clk);
            guard++;
        end
        tests++;
        if (model_q.size() != 0 || empty !== 1'b1 || m_valid !== 1'b0 || count !== '0) begin
            fails++;
            $display("[TB] FAIL drain_end: got left=%0d empty=%b m_valid=%b count=%0d expected 0/1/0/0", model_q.size(), empty, m_valid, count);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [3:0]    pat;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        pat = 4'b1001;
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1; s_data = $urandom;
            @(negedge clk);
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step();
        end
        prev_stall = 1'b0; prev_data = '0;
        for (int k = 0; k < 40 && model_q.size() > 0; k++) begin
            m_ready = pat[k % 4];
            @(negedge clk);
            if (prev_stall) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    fails++;
                    $display("[TB] FAIL bp_hold: got m_valid=%b m_data=%h expected 1/%h", m_valid, m_data, prev_data);
                end
            end
            if (m_valid) begin
                tests++;
                if (m_data !== model_q[0]) begin
                    fails++;
                    $display("[TB] FAIL bp_order: got %h expected %h", m_data, model_q[0]);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            step();
        end
        m_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (model_q.size() != 0 || count !== '0) begin
            fails++;
            $display("[TB] FAIL bp_end: got left=%0d count=%0d expected 0/0", model_q.size(), count);
        end
        step();
    endtask

    task automatic test_wrap();
        int            pushed;
        int            idle_run;
        bit            saw_wwrap;
        bit            saw_rwrap;
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        pushed = 0; idle_run = 0; saw_wwrap = 0; saw_rwrap = 0;
        prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 30000 && (pushed < 3000 || model_q.size() > 0); cyc++) begin
            s_valid = (pushed < 3000) && ($urandom_range(0, 9) < 7);
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            tests++;
            if ({s_ready, full, empty} !== {model_q.size() < DEPTH, model_q.size() == DEPTH, model_q.size() == 0}
                || count !== (AW+1)'(model_q.size())) begin
                fails++;
                $display("[TB] FAIL wrap_status: got ready/full/empty=%b count=%0d expected size %0d", {s_ready, full, empty}, count, model_q.size());
            end
            tests++;
            if (mem_wen !== (s_valid && model_q.size() < DEPTH) || (mem_wen && mem_waddr !== AW'(wr_total % DEPTH))) begin
                fails++;
                $display("[TB] FAIL wrap_write: got wen=%b addr=%0d expected addr %0d", mem_wen, mem_waddr, wr_total % DEPTH);
            end
            if (mem_ren) begin
                tests++;
                if (mem_raddr !== AW'(rd_total % DEPTH) || rd_total >= wr_total) begin
                    fails++;
                    $display("[TB] FAIL wrap_read: got raddr=%0d reads=%0d writes=%0d expected addr %0d", mem_raddr, rd_total, wr_total, rd_total % DEPTH);
                end
            end
            if (m_valid) begin
                tests++;
                if (model_q.size() == 0 || m_data !== model_q[0]) begin
                    fails++;
                    $display("[TB] FAIL wrap_order: got %h expected %h (size %0d)", m_data, (model_q.size() > 0) ? model_q[0] : '0, model_q.size());
                end
            end
            if (prev_stall) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    fails++;
                    $display("[TB] FAIL wrap_hold: got m_valid=%b m_data=%h expected 1/%h", m_valid, m_data, prev_data);
                end
            end
            idle_run = (model_q.size() > 0 && !m_valid) ? idle_run + 1 : 0;
            if (idle_run > 3) begin
                tests++; fails++;
                $display("[TB] FAIL wrap_stuck: got no output for %0d cycles with %0d words stored expected <=3", idle_run, model_q.size());
                idle_run = 0;
            end
            if (mem_wen && mem_waddr == '0) saw_wwrap = 1;
            if (mem_ren && mem_raddr == '0) saw_rwrap = 1;
            if (s_valid && model_q.size() < DEPTH) pushed++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            step();
        end
        tests++;
        if (!saw_wwrap || !saw_rwrap || model_q.size() != 0 || pushed != 3000) begin
            fails++;
            $display("[TB] FAIL wrap_end: got wwrap=%0b rwrap=%0b left=%0d pushed=%0d expected 1/1/0/3000", saw_wwrap, saw_rwrap, model_q.size(), pushed);
        end
        s_valid = 1'b0; m_ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = $urandom;
            @(negedge clk);
            step();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            step();
        end
        // Push and pop together so a read is issued and count stays at 5.
        s_valid = 1'b1; m_ready = 1'b1; s_data = $urandom;
        @(negedge clk);
        tests++;
        if (count !== (AW+1)'(5) || m_valid !== 1'b1 || mem_ren !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_setup: got count=%0d m_valid=%b ren=%b expected 5/1/1", count, m_valid, mem_ren);
        end
        step();
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (count !== '0 || m_valid !== 1'b0 || empty !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_cleared: got count=%0d m_valid=%b empty=%b expected 0/0/1", count, m_valid, empty);
        end
        step();
        s_valid = 1'b1; m_ready = 1'b1; s_data = 32'h1234_5678;
        @(negedge clk);
        tests++;
        if (mem_wen !== 1'b1 || mem_waddr !== AW'(0)) begin
            fails++;
            $display("[TB] FAIL mid_push_addr: got wen=%b addr=%0d expected 1/0", mem_wen, mem_waddr);
        end
        step();
        s_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++;
            if (m_valid !== (i == 3) || (i == 3 && m_data !== 32'h1234_5678)) begin
                fails++;
                $display("[TB] FAIL mid_readback[%0d]: got m_valid=%b m_data=%h expected %0b/12345678", i, m_valid, m_data, i == 3);
            end
            step();
        end
        @(negedge clk);
        tests++;
        if (empty !== 1'b1 || model_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL mid_end: got empty=%b left=%0d expected 1/0", empty, model_q.size());
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_latency();
        test_fill_full();
        test_backpressure();
        test_wrap();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "[TB] timeout");
    end

endmodule
